// File: rtl/mau_pkg.sv
// Shared definitions for the mem_access_unit load/store engine: size codes,
// FSM states, byte-select constants and lane helpers.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  localparam logic [3:0] SEL_W    = 4'b1111;
  localparam logic [3:0] SEL_HL   = 4'b0011;
  localparam logic [3:0] SEL_HH   = 4'b1100;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } mau_state_e;

  // Reserved size falls through to the word encoding.
  function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                          input logic [1:0] boff);
    logic [3:0] sel;
    sel = SEL_W;
    case (size)
      SZ_B:    sel = 4'b0001 << boff;
      SZ_H:    sel = boff[1] ? SEL_HH : SEL_HL;
      default: sel = SEL_W;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    case (size)
      SZ_B:    d = {4{wd[7:0]}};
      SZ_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] boff);
    logic m;
    m = 1'b0;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = boff[0];
      SZ_W:    m = |boff;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_load_ext.sv
// Sign/zero extension of right-aligned load data according to access size.
module mau_load_ext
  import mau_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic fill_b;
  logic fill_h;

  assign fill_b = data_i[7]  & ~uns_i;
  assign fill_h = data_i[15] & ~uns_i;

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_B:    data_o = {{24{fill_b}}, data_i[7:0]};
      SZ_H:    data_o = {{16{fill_h}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store engine for the byte-lane data memory.
// Optional misalignment exception: define MAU_MISALIGN_EXC_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: a request is taken on a rising edge where req=1 and ready=1;
  // req while ready=0 is dropped, and done pulses one cycle per request.
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [3:0]            mem_sel,
  output logic [DATA_WIDTH-1:0] mem_inD,
  output logic                  mem_str,
  input  logic [DATA_WIDTH-1:0] mem_outD,
  output logic [1:0]            dbg_state
);

  mau_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_A_q, mem_A_d;
  logic [3:0]            mem_sel_q, mem_sel_d;
  logic [DATA_WIDTH-1:0] mem_inD_q, mem_inD_d;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  misalign;

`ifdef MAU_MISALIGN_EXC_EN
  assign misalign = is_misaligned(size, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mau_load_ext u_load_ext (
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_i (mem_outD),
    .data_o (load_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mem_A_q   <= '0;
      mem_sel_q <= SEL_NONE;
      mem_inD_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      mem_A_q   <= mem_A_d;
      mem_sel_q <= mem_sel_d;
      mem_inD_q <= mem_inD_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_A_d   = mem_A_q;
    mem_sel_d = mem_sel_q;
    mem_inD_d = mem_inD_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          mem_A_d = addr[ADDR_WIDTH+1:2];
          if (misalign) begin
            // Rejected access: skip the memory entirely and report at once.
            state_d   = DONE;
            done_d    = 1'b1;
            err_d     = 1'b1;
            mem_sel_d = SEL_NONE;
          end else begin
            state_d   = ACCESS;
            mem_sel_d = lane_sel(size, addr[1:0]);
            mem_inD_d = lane_data(size, wdata);
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d   = DONE;
          done_d    = 1'b1;
          mem_sel_d = SEL_NONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Memory read data is valid now (one cycle after the ACCESS edge).
        rdata_d   = load_ext;
        state_d   = DONE;
        done_d    = 1'b1;
        mem_sel_d = SEL_NONE;
      end
      DONE: begin
        state_d   = IDLE;
        mem_sel_d = SEL_NONE;
      end
      default: begin
        state_d   = IDLE;
        mem_sel_d = SEL_NONE;
      end
    endcase
  end

  // Strobe is decoded from state so an asynchronous reset removes it at once.
  assign mem_str   = (state_q == ACCESS) && we_q;
  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_A     = mem_A_q;
  assign mem_sel   = mem_sel_q;
  assign mem_inD   = mem_inD_q;
  assign dbg_state = state_q;

endmodule
